// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: the 34-bit instruction
// field map, the idle word, FSM state codes and phase-length helpers.
package core_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 16;

  // Instruction field positions
  localparam int ACC_B      = 33;
  localparam int CEN_PMEM_B = 32;
  localparam int WEN_PMEM_B = 31;
  localparam int A_PMEM_LSB = 20;
  localparam int CEN_XMEM_B = 19;
  localparam int WEN_XMEM_B = 18;
  localparam int A_XMEM_LSB = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXECUTE_B  = 1;
  localparam int LOAD_B     = 0;

  // Both SRAMs deselected, write-enables inactive, every strobe low.
  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1800C0000;

  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] S_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] S_W_L0    = 4'd1;
  localparam logic [STATE_W-1:0] S_W_LOAD  = 4'd2;
  localparam logic [STATE_W-1:0] S_W_DRAIN = 4'd3;
  localparam logic [STATE_W-1:0] S_X_L0    = 4'd4;
  localparam logic [STATE_W-1:0] S_EXEC    = 4'd5;
  localparam logic [STATE_W-1:0] S_E_DRAIN = 4'd6;
  localparam logic [STATE_W-1:0] S_OUT     = 4'd7;
  localparam logic [STATE_W-1:0] S_DONE    = 4'd8;

  // L0 fill phases run one extra cycle to absorb the SRAM read latency.
  function automatic int w_l0_cycles(input int n_col);
    return n_col + 1;
  endfunction

  function automatic int w_load_cycles(input int n_col);
    return n_col;
  endfunction

  function automatic int w_drain_cycles(input int n_row);
    return n_row;
  endfunction

  function automatic int x_l0_cycles(input int n_nij);
    return n_nij + 1;
  endfunction

  function automatic int exec_cycles(input int n_nij);
    return n_nij;
  endfunction

  function automatic int e_drain_cycles(input int n_row, input int n_col);
    return n_row + n_col;
  endfunction

endpackage

// File: rtl/core_inst_sequencer_xmem_rd.sv
// Burst reader shared by the weight and activation L0 fill phases: walks xmem
// addresses base..base+len-1 and raises l0_wr one cycle behind each read.
module xmem_burst_reader
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  len,
  input  logic [CNT_W-1:0]  cnt,
  output logic              cen_n,
  output logic [ADDR_W-1:0] addr,
  output logic              l0_wr
);

  logic reading;
  logic rd_q;

  assign reading = active && (cnt < len);
  assign cen_n   = ~reading;
  assign addr    = reading ? base + ADDR_W'(cnt) : '0;
  // Data appears at the SRAM output one cycle after the read was issued.
  assign l0_wr   = active && rd_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= reading;
    end
  end

endmodule

// File: rtl/core_inst_sequencer.sv
// Generates the core instruction stream for one weight-stationary convolution
// pass: per kernel offset, fill/load weights, stream activations, drain to pmem.
module core_inst_sequencer
  import core_pkg::*;
#(
  parameter int                row     = 8,
  parameter int                col     = 8,
  parameter int                kij     = 9,
  parameter int                len_nij = 36,
  parameter logic [ADDR_W-1:0] w_base  = 11'd0,
  parameter logic [ADDR_W-1:0] x_base  = 11'd1024,
  parameter logic [ADDR_W-1:0] p_base  = 11'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] phase_next;
  logic [CNT_W-1:0]   phase_cnt;
  logic [CNT_W-1:0]   phase_len;
  logic [CNT_W-1:0]   out_cnt;
  logic               phase_last;
  logic               out_last;
  logic               kij_last;

  logic               xb_active;
  logic [ADDR_W-1:0]  xb_base;
  logic [CNT_W-1:0]   xb_len;
  logic               xb_cen_n;
  logic [ADDR_W-1:0]  xb_addr;
  logic               xb_l0_wr;
  logic [ADDR_W-1:0]  p_addr;
  logic [INST_W-1:0]  inst_nxt;

  // Length and successor of each fixed-length phase.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    phase_len  = CNT_W'(1);
    phase_next = S_IDLE;
    case (state)
      S_W_L0: begin
        phase_len  = CNT_W'(w_l0_cycles(col));
        phase_next = S_W_LOAD;
      end
      S_W_LOAD: begin
        phase_len  = CNT_W'(w_load_cycles(col));
        phase_next = S_W_DRAIN;
      end
      S_W_DRAIN: begin
        phase_len  = CNT_W'(w_drain_cycles(row));
        phase_next = S_X_L0;
      end
      S_X_L0: begin
        phase_len  = CNT_W'(x_l0_cycles(len_nij));
        phase_next = S_EXEC;
      end
      S_EXEC: begin
        phase_len  = CNT_W'(exec_cycles(len_nij));
        phase_next = S_E_DRAIN;
      end
      S_E_DRAIN: begin
        phase_len  = CNT_W'(e_drain_cycles(row, col));
        phase_next = S_OUT;
      end
      default: ;
    endcase
  end

  assign phase_last = (phase_cnt == phase_len - CNT_W'(1));
  assign out_last   = (out_cnt == CNT_W'(len_nij - 1));
  assign kij_last   = (kij_idx == 4'(kij - 1));

  assign xb_active = (state == S_W_L0) || (state == S_X_L0);
  assign xb_base   = (state == S_W_L0) ? w_base + ADDR_W'(kij_idx * col) : x_base;
  assign xb_len    = (state == S_W_L0) ? CNT_W'(col) : CNT_W'(len_nij);

  xmem_burst_reader u_xmem_rd (
    .clk    (clk),
    .reset  (reset),
    .active (xb_active),
    .base   (xb_base),
    .len    (xb_len),
    .cnt    (phase_cnt),
    .cen_n  (xb_cen_n),
    .addr   (xb_addr),
    .l0_wr  (xb_l0_wr)
  );

  // Address arithmetic wraps modulo 2048 by construction.
  assign p_addr = p_base + ADDR_W'(kij_idx * len_nij) + ADDR_W'(out_cnt);

  always_comb begin
    inst_nxt             = IDLE_WORD;
    inst_nxt[ACC_B]      = 1'b0;
    inst_nxt[IFIFO_WR_B] = 1'b0;
    inst_nxt[IFIFO_RD_B] = 1'b0;
    case (state)
      S_W_L0, S_X_L0: begin
        inst_nxt[CEN_XMEM_B]               = xb_cen_n;
        inst_nxt[WEN_XMEM_B]               = 1'b1;
        inst_nxt[A_XMEM_LSB +: ADDR_W]     = xb_addr;
        inst_nxt[L0_WR_B]                  = xb_l0_wr;
      end
      S_W_LOAD: begin
        inst_nxt[L0_RD_B] = 1'b1;
        inst_nxt[LOAD_B]  = 1'b1;
      end
      S_EXEC: begin
        inst_nxt[L0_RD_B]   = 1'b1;
        inst_nxt[EXECUTE_B] = 1'b1;
      end
      S_OUT: begin
        // Show-ahead OFIFO: pop and write pmem in the cycle valid is seen.
        if (ofifo_valid) begin
          inst_nxt[OFIFO_RD_B]           = 1'b1;
          inst_nxt[CEN_PMEM_B]           = 1'b0;
          inst_nxt[WEN_PMEM_B]           = 1'b0;
          inst_nxt[A_PMEM_LSB +: ADDR_W] = p_addr;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      out_cnt   <= '0;
      kij_idx   <= '0;
      inst      <= IDLE_WORD;
    end else begin
      inst <= inst_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_W_L0;
            phase_cnt <= '0;
            out_cnt   <= '0;
            kij_idx   <= '0;
          end
        end
        S_W_L0, S_W_LOAD, S_W_DRAIN, S_X_L0, S_EXEC, S_E_DRAIN: begin
          if (phase_last) begin
            phase_cnt <= '0;
            state     <= phase_next;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (ofifo_valid) begin
            if (out_last) begin
              out_cnt <= '0;
              if (kij_last) begin
                state <= S_DONE;
              end else begin
                kij_idx <= kij_idx + 4'd1;
                state   <= S_W_L0;
              end
            end else begin
              out_cnt <= out_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench for core_inst_sequencer: expected instruction stream is
// built phase by phase from the pass rules and compared cycle by cycle.
module tb_core_inst_sequencer;

  localparam int          ROW = 8;
  localparam int          COL = 8;
  localparam int          KIJ = 9;
  localparam int          LEN = 36;
  localparam logic [10:0] WB  = 11'd0;
  localparam logic [10:0] XB  = 11'd1024;
  localparam logic [10:0] PB  = 11'd0;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  core_inst_sequencer #(
    .row(ROW), .col(COL), .kij(KIJ), .len_nij(LEN),
    .w_base(WB), .x_base(XB), .p_base(PB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij_idx     (kij_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: expected decode word and kij per cycle after start.
  bit          valid_tab[$];
  logic [33:0] exp_word[$];
  int          exp_kij[$];

  function automatic void push(input logic [33:0] w, input int k);
    exp_word.push_back(w);
    exp_kij.push_back(k);
  endfunction

  function automatic logic [33:0] xrd_word(input int i, input int n, input logic [10:0] base);
    logic [33:0] w;
    w = IDLE_W;
    if (i < n) begin
      w[19]   = 1'b0;
      w[17:7] = base + 11'(i);
    end
    if (i >= 1) w[2] = 1'b1;
    return w;
  endfunction

  function automatic logic [33:0] pm_word(input logic [10:0] a);
    logic [33:0] w;
    w        = IDLE_W;
    w[32]    = 1'b0;
    w[31]    = 1'b0;
    w[30:20] = a;
    w[6]     = 1'b1;
    return w;
  endfunction

  task automatic build_model(input int mode);
    int n;
    int t;
    valid_tab.delete();
    for (int i = 0; i < 3000; i++) begin
      case (mode)
        0:       valid_tab.push_back(1'b1);
        1:       valid_tab.push_back($urandom_range(0, 3) != 0);
        default: valid_tab.push_back(!(i >= 124 && i <= 128));
      endcase
    end
    exp_word.delete();
    exp_kij.delete();
    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i <= COL; i++) push(xrd_word(i, COL, WB + 11'(k * COL)), k);
      for (int i = 0; i < COL; i++) push(IDLE_W | 34'h9, k);
      for (int i = 0; i < ROW; i++) push(IDLE_W, k);
      for (int i = 0; i <= LEN; i++) push(xrd_word(i, LEN, XB), k);
      for (int i = 0; i < LEN; i++) push(IDLE_W | 34'hA, k);
      for (int i = 0; i < ROW + COL; i++) push(IDLE_W, k);
      n = 0;
      while (n < LEN) begin
        t = exp_word.size();
        if (t >= valid_tab.size()) valid_tab.push_back(1'b1);
        if (valid_tab[t]) begin
          push(pm_word(PB + 11'(k * LEN + n)), k);
          n++;
        end else begin
          push(IDLE_W, k);
        end
      end
    end
    push(IDLE_W, KIJ - 1);
  endtask

  // Runs one pass; abort_at >= 0 resets mid-pass, spur_at >= 0 pulses start while busy.
  task automatic run_pass(input int mode, input int abort_at, input int spur_at, input int exp_done_at);
    int          len;
    int          done_at;
    int          n_wr;
    logic [33:0] exp_i;
    build_model(mode);
    len     = exp_word.size();
    done_at = -1;
    n_wr    = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c <= len + 1; c++) begin
      @(posedge clk); #1;
      exp_i = (c == 0 || c - 1 >= len) ? IDLE_W : exp_word[c-1];
      check("inst", inst, exp_i);
      check("busy", busy, c < len);
      check("done", done, c == len - 1);
      if (c < len) check("kij_idx", kij_idx, exp_kij[c]);
      if (done && done_at < 0) done_at = c;
      if (inst[32] == 1'b0) begin
        check("pmem_addr", inst[30:20], PB + 11'(n_wr));
        n_wr++;
      end
      start       = (c == spur_at);
      ofifo_valid = (c < valid_tab.size()) ? valid_tab[c] : 1'b1;
      if (c == abort_at) begin
        check("pre_reset_kij", kij_idx, 3);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_inst", inst, IDLE_W);
        check("rst_kij", kij_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        start = 1'b0;
        return;
      end
    end
    check("done_cycle", done_at, len - 1);
    if (exp_done_at >= 0) check("pass_len", done_at, exp_done_at);
    check("pmem_writes", n_wr, KIJ * LEN);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_inst", inst, IDLE_W);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_kij", kij_idx, 0);
    end
    run_pass(0, -1, 200, 1350);
    run_pass(2, -1, -1, 1355);
    run_pass(1, -1, 1000, -1);
    run_pass(0, 3 * 150 + 70, -1, -1);
    run_pass(1, -1, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
